demux_rr: RTL and testbench

Parametrised 1-to-N demultiplexer with per-output holding registers and valid/ready flow control; it generalises the team's fixed 4-bit, 2-output demux. It sits between a single upstream producer and N_CH downstream consumers. Words are steered either round-robin (the legacy alternating behaviour, extended to N channels) or by an explicit channel select, and downstream stalls propagate back to the producer.

---
 rtl/demux_rr_if.sv | 37 +++
 rtl/demux_rr.sv | 106 ++++++++++
 tb/tb_demux_rr.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/demux_rr_if.sv
// Handshake bundle between one producer, the demux_rr block and N_CH consumers.
// DEMUX_SELCHK_EN adds the err_out signal to the bundle and both modports.
interface demux_rr_if #(
  parameter int WIDTH = 4,
  parameter int N_CH  = 2,
  parameter int SEL_W = 1
);
  logic                    mode;
  logic                    valid_in;
  logic [WIDTH-1:0]        data_in;
  logic [SEL_W-1:0]        sel_in;
  logic                    in_ready;
  logic [N_CH*WIDTH-1:0]   data_out;
  logic [N_CH-1:0]         valid_out;
  logic [N_CH-1:0]         ready_in;
`ifdef DEMUX_SELCHK_EN
  logic                    err_out;

  modport master (
    output mode, valid_in, data_in, sel_in, ready_in,
    input  in_ready, data_out, valid_out, err_out
  );
  modport slave (
    input  mode, valid_in, data_in, sel_in, ready_in,
    output in_ready, data_out, valid_out, err_out
  );
`else
  modport master (
    output mode, valid_in, data_in, sel_in, ready_in,
    input  in_ready, data_out, valid_out
  );
  modport slave (
    input  mode, valid_in, data_in, sel_in, ready_in,
    output in_ready, data_out, valid_out
  );
`endif
endinterface

// File: rtl/demux_rr.sv
// 1-to-N_CH demux with one holding register per channel, round-robin or addressed steering.
// DEMUX_SELCHK_EN: accept-and-discard out-of-range selects and flag them on err_out.
module demux_rr #(
  parameter int WIDTH = 4,
  parameter int N_CH  = 2,
  parameter int SEL_W = 1
) (
  input  logic       clk,
  input  logic       reset,
  demux_rr_if.slave  bus
);

  localparam logic [SEL_W:0]   N_CH_W  = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [N_CH-1:0]             full_q, full_d;
  logic [N_CH-1:0][WIDTH-1:0]  data_q, data_d;
`ifdef DEMUX_SELCHK_EN
  logic                        err_q, err_d;
`endif

  logic [SEL_W-1:0]            tgt;
  logic                        tgt_oob;
  logic                        in_ready;
  logic                        accept;
  logic [N_CH-1:0]             load;
  logic [N_CH-1:0]             drain;

  // Target channel; out-of-range only reachable in addressed mode with non-power-of-two N_CH.
  always_comb begin
    tgt     = bus.mode ? bus.sel_in : rr_ptr_q;
    tgt_oob = bus.mode && ({1'b0, bus.sel_in} >= N_CH_W);
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      if (tgt_oob) begin
`ifdef DEMUX_SELCHK_EN
        in_ready = 1'b1;
`else
        in_ready = 1'b0;
`endif
      end else begin
        in_ready = ~full_q[tgt] | bus.ready_in[tgt];
      end
    end
  end

  assign accept = bus.valid_in & in_ready;
  assign drain  = full_q & bus.ready_in;

  always_comb begin
    load   = '0;
    data_d = data_q;
    for (int i = 0; i < N_CH; i++) begin
      load[i] = accept && !tgt_oob && (tgt == SEL_W'(i));
      if (load[i]) begin
        data_d[i] = bus.data_in;
      end
    end
    // A load wins over a drain on the same channel: word replaced, flag stays set.
    full_d = (full_q & ~drain) | load;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && !bus.mode) begin
      rr_ptr_d = (rr_ptr_q == LAST_CH) ? '0 : rr_ptr_q + 1'b1;
    end
  end

`ifdef DEMUX_SELCHK_EN
  assign err_d = accept & tgt_oob;
`endif

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      full_q   <= '0;
      // NOTE: the data words are reset as well because data_out must read zero after reset.
      data_q   <= '0;
`ifdef DEMUX_SELCHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      rr_ptr_q <= rr_ptr_d;
      full_q   <= full_d;
      data_q   <= data_d;
`ifdef DEMUX_SELCHK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.valid_out = full_q;
  assign bus.data_out  = data_q;
`ifdef DEMUX_SELCHK_EN
  assign bus.err_out   = err_q;
`endif

endmodule

// File: tb/tb_demux_rr.sv
// Directed bench for demux_rr: three instances (N_CH = 2, 4, 3) with a scoreboard of
// expected (channel, word) pairs pushed at drive time and popped after the accepting edge.
module tb_demux_rr;

  logic clk;
  logic reset;

  demux_rr_if #(.WIDTH(4), .N_CH(2), .SEL_W(1)) if2 ();
  demux_rr_if #(.WIDTH(4), .N_CH(4), .SEL_W(2)) if4 ();
  demux_rr_if #(.WIDTH(4), .N_CH(3), .SEL_W(2)) if3 ();

  demux_rr #(.WIDTH(4), .N_CH(2), .SEL_W(1)) u2 (.clk(clk), .reset(reset), .bus(if2));
  demux_rr #(.WIDTH(4), .N_CH(4), .SEL_W(2)) u4 (.clk(clk), .reset(reset), .bus(if4));
  demux_rr #(.WIDTH(4), .N_CH(3), .SEL_W(2)) u3 (.clk(clk), .reset(reset), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [3:0] d;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input int ch, input logic [3:0] d);
    exp_t e;
    e.ch = ch;
    e.d  = d;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input string tag, input logic [63:0] dout, input logic [15:0] vout);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_total++;
      $error("FAIL %s: observed empty scoreboard expected a pending word", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_valid"}, 64'(vout[e.ch]), 64'd1);
      check({tag, "_data"}, 64'(dout[e.ch*4 +: 4]), 64'(e.d));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    if2.mode = 1'b0; if2.valid_in = 1'b0; if2.data_in = '0; if2.sel_in = '0; if2.ready_in = '0;
    if4.mode = 1'b0; if4.valid_in = 1'b0; if4.data_in = '0; if4.sel_in = '0; if4.ready_in = '0;
    if3.mode = 1'b0; if3.valid_in = 1'b0; if3.data_in = '0; if3.sel_in = '0; if3.ready_in = '0;

    // Reset values: in_ready low during reset even with a word offered.
    if2.valid_in = 1'b1; if2.data_in = 4'hF; if2.ready_in = 2'b11;
    #1;
    check("rst_in_ready", 64'(if2.in_ready), 64'd0);
    tick();
    check("rst_valid_out", 64'(if2.valid_out), 64'd0);
    check("rst_data_out", 64'(if2.data_out), 64'h00);
    check("rst_valid_out_n4", 64'(if4.valid_out), 64'd0);
`ifdef DEMUX_SELCHK_EN
    check("rst_err_out", 64'(if3.err_out), 64'd0);
`endif
    reset = 1'b0;

    // Round-robin on N_CH=2, one word per cycle.
    if2.data_in = 4'h8; #1;
    check("rr_ready0", 64'(if2.in_ready), 64'd1);
    push(0, 4'h8); tick(); sb_check("rr_w0", 64'(if2.data_out), 16'(if2.valid_out));
    if2.data_in = 4'h4; #1;
    check("rr_ready1", 64'(if2.in_ready), 64'd1);
    push(1, 4'h4); tick(); sb_check("rr_w1", 64'(if2.data_out), 16'(if2.valid_out));
    check("rr_ch0_drained", 64'(if2.valid_out), 64'b10);
    if2.data_in = 4'hE;
    push(0, 4'hE); tick(); sb_check("rr_w2", 64'(if2.data_out), 16'(if2.valid_out));
    if2.data_in = 4'h7;
    push(1, 4'h7); tick(); sb_check("rr_w3", 64'(if2.data_out), 16'(if2.valid_out));
    if2.valid_in = 1'b0;
    tick();
    check("rr_idle_valid", 64'(if2.valid_out), 64'd0);
    check("rr_data_retained", 64'(if2.data_out), 64'h7E);

    // Backpressure on N_CH=4, addressed channel 2 stalled.
    if4.mode = 1'b1; if4.sel_in = 2'd2; if4.ready_in = 4'b1011;
    if4.valid_in = 1'b1; if4.data_in = 4'hA; #1;
    check("bp_ready_first", 64'(if4.in_ready), 64'd1);
    push(2, 4'hA); tick(); sb_check("bp_w0", 64'(if4.data_out), 16'(if4.valid_out));
    if4.data_in = 4'h5; #1;
    check("bp_ready_stall", 64'(if4.in_ready), 64'd0);
    tick();
    check("bp_held_valid", 64'(if4.valid_out), 64'b0100);
    check("bp_held_data", 64'(if4.data_out[8 +: 4]), 64'hA);
    if4.ready_in = 4'b1111; #1;
    check("bp_ready_release", 64'(if4.in_ready), 64'd1);
    push(2, 4'h5); tick(); sb_check("bp_w1", 64'(if4.data_out), 16'(if4.valid_out));
    check("bp_drain_load_valid", 64'(if4.valid_out), 64'b0100);
    if4.valid_in = 1'b0;
    tick();
    check("bp_empty", 64'(if4.valid_out), 64'd0);

    // Pointer wrap on N_CH=3, then addressed words, then back to round-robin.
    if3.mode = 1'b0; if3.ready_in = 3'b111; if3.valid_in = 1'b1;
    if3.data_in = 4'h1; push(0, 4'h1); tick(); sb_check("wrap_w0", 64'(if3.data_out), 16'(if3.valid_out));
    if3.data_in = 4'h2; push(1, 4'h2); tick(); sb_check("wrap_w1", 64'(if3.data_out), 16'(if3.valid_out));
    if3.data_in = 4'h3; push(2, 4'h3); tick(); sb_check("wrap_w2", 64'(if3.data_out), 16'(if3.valid_out));
    if3.mode = 1'b1; if3.sel_in = 2'd2;
    if3.data_in = 4'hB; push(2, 4'hB); tick(); sb_check("wrap_a0", 64'(if3.data_out), 16'(if3.valid_out));
    if3.data_in = 4'hC; push(2, 4'hC); tick(); sb_check("wrap_a1", 64'(if3.data_out), 16'(if3.valid_out));
    if3.mode = 1'b0;
    if3.data_in = 4'hD; push(0, 4'hD); tick(); sb_check("wrap_back", 64'(if3.data_out), 16'(if3.valid_out));
    check("wrap_only_ch0", 64'(if3.valid_out), 64'b001);
    if3.valid_in = 1'b0;
    tick();

    // Reset mid-operation: fill channels 0 and 1 (rr_ptr currently 1), then reset.
    if3.mode = 1'b1; if3.ready_in = 3'b000; if3.valid_in = 1'b1;
    if3.sel_in = 2'd0; if3.data_in = 4'h6; push(0, 4'h6); tick();
    sb_check("mid_fill0", 64'(if3.data_out), 16'(if3.valid_out));
    if3.sel_in = 2'd1; if3.data_in = 4'h7; push(1, 4'h7); tick();
    sb_check("mid_fill1", 64'(if3.data_out), 16'(if3.valid_out));
    check("mid_full", 64'(if3.valid_out), 64'b011);
    reset = 1'b1; if3.sel_in = 2'd2; #1;
    check("mid_rst_in_ready", 64'(if3.in_ready), 64'd0);
    tick();
    reset = 1'b0;
    check("mid_rst_valid", 64'(if3.valid_out), 64'd0);
    check("mid_rst_data", 64'(if3.data_out), 64'h000);
    if3.mode = 1'b0; if3.ready_in = 3'b111; if3.data_in = 4'h9;
    push(0, 4'h9); tick(); sb_check("mid_after_rst", 64'(if3.data_out), 16'(if3.valid_out));
    check("mid_after_rst_only_ch0", 64'(if3.valid_out), 64'b001);
    if3.valid_in = 1'b0;
    tick();
    check("sel_base_empty", 64'(if3.valid_out), 64'd0);

    // Out-of-range select on N_CH=3.
    if3.mode = 1'b1; if3.sel_in = 2'd3; if3.data_in = 4'h9; if3.valid_in = 1'b1; #1;
`ifdef DEMUX_SELCHK_EN
    check("selchk_in_ready", 64'(if3.in_ready), 64'd1);
    tick();
    if3.valid_in = 1'b0;
    check("selchk_err_hi", 64'(if3.err_out), 64'd1);
    check("selchk_no_valid", 64'(if3.valid_out), 64'd0);
    tick();
    check("selchk_err_lo", 64'(if3.err_out), 64'd0);
    check("selchk_still_empty", 64'(if3.valid_out), 64'd0);
`else
    check("sel_oob_in_ready", 64'(if3.in_ready), 64'd0);
    tick();
    check("sel_oob_no_valid", 64'(if3.valid_out), 64'd0);
    check("sel_oob_still_stalled", 64'(if3.in_ready), 64'd0);
    if3.sel_in = 2'd0; #1;
    check("sel_oob_recover_ready", 64'(if3.in_ready), 64'd1);
    push(0, 4'h9); tick(); sb_check("sel_oob_recover", 64'(if3.data_out), 16'(if3.valid_out));
    if3.valid_in = 1'b0;
`endif

    tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
